// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared tempo constants and width helpers for the step sequencer
package seq_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator limit: one step per (CLK_HZ*60) units of bpm*steps_per_beat
  function automatic longint bpm_limit(input longint clk_hz);
    return clk_hz * 64'd60;
  endfunction

  function automatic int acc_width(input longint limit, input int inc_w);
    return $clog2(limit + (longint'(1) << inc_w));
  endfunction

endpackage

// File: rtl/tempo_nco.sv
// rtl/tempo_nco.sv - phase-accumulator tempo generator, one-clk tick per step
module tempo_nco
  import seq_pkg::*;
#(
  parameter int     INC_W = 10,
  parameter longint LIMIT = 60000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [INC_W-1:0] inc,
  output logic             tick
);

  localparam int ACC_W = acc_width(LIMIT, INC_W);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;

  assign w_sum = r_acc + ACC_W'(inc);
  assign tick  = run && (w_sum >= ACC_W'(LIMIT));

  // Stopping clears the phase so every run starts from a full step period.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      r_acc <= '0;
    end else if (tick) begin
      r_acc <= w_sum - ACC_W'(LIMIT);
    end else begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - N-track x S-step drum sequencer with tempo NCO
// Optional odd-step swing delay enabled by defining SWING_EN.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_TRACKS     = 4,
  parameter int NUM_STEPS      = 8,
  parameter int CLK_HZ         = 50000000,
  parameter int BPM_W          = 8,
  parameter int STEPS_PER_BEAT = 2
`ifdef SWING_EN
  , parameter int SWING_SHIFT  = 12
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 play,
  input  logic                                 bpm_load,
  input  logic [BPM_W-1:0]                     bpm_in,
  input  logic                                 pat_we,
  input  logic [idx_w(NUM_TRACKS)-1:0]         pat_track,
  input  logic [NUM_STEPS-1:0]                 pat_data,
  input  logic [NUM_TRACKS-1:0]                mute,
`ifdef SWING_EN
  input  logic [3:0]                           swing_in,
`endif
  output logic [NUM_TRACKS-1:0]                trig_out,
  output logic [idx_w(NUM_STEPS)-1:0]          step_idx,
  output logic                                 step_tick,
  output logic [NUM_TRACKS*NUM_STEPS-1:0]      pattern_out
);

  localparam int     STEP_W = idx_w(NUM_STEPS);
  localparam int     INC_W  = BPM_W + idx_w(STEPS_PER_BEAT + 1);
  localparam longint LIMIT  = bpm_limit(longint'(CLK_HZ));

  logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] r_pattern;
  logic [BPM_W-1:0]                     r_bpm;
  logic                                 r_play;
  logic [STEP_W-1:0]                    r_step;
  logic [NUM_TRACKS-1:0]                r_trig;
  logic                                 r_step_tick;

  logic                  w_start;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_wr_ok;
  logic [INC_W-1:0]      w_inc;
  logic [STEP_W-1:0]     w_next_step;
  logic [STEP_W-1:0]     w_sel_step;
  logic [NUM_TRACKS-1:0] w_col;

  assign w_start     = play & ~r_play;
  assign w_run       = play & r_play;
  assign w_inc       = INC_W'(r_bpm) * INC_W'(STEPS_PER_BEAT);
  assign w_wr_ok     = pat_we && (32'(pat_track) < 32'(NUM_TRACKS));
  assign w_next_step = (r_step == STEP_W'(NUM_STEPS - 1)) ? '0 : r_step + 1'b1;
  assign w_sel_step  = w_start ? '0 : w_next_step;

  // Column read uses the registered pattern, so a same-cycle write is not seen.
  always_comb begin
    w_col = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      w_col[t] = r_pattern[t][w_sel_step];
    end
  end

  tempo_nco #(
    .INC_W (INC_W),
    .LIMIT (LIMIT)
  ) u_nco (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .inc   (w_inc),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern   <= '0;
      r_bpm       <= '0;
      r_play      <= 1'b0;
      r_step      <= '0;
      r_step_tick <= 1'b0;
    end else begin
      r_play <= play;
      if (bpm_load) r_bpm <= bpm_in;
      if (w_wr_ok) r_pattern[pat_track] <= pat_data;
      if (!play || w_start) begin
        r_step      <= '0;
        r_step_tick <= 1'b0;
      end else if (w_tick) begin
        r_step      <= w_next_step;
        r_step_tick <= 1'b1;
      end else begin
        r_step_tick <= 1'b0;
      end
    end
  end

`ifdef SWING_EN
  localparam int SW_CNT_W = 4 + SWING_SHIFT;

  logic [NUM_TRACKS-1:0] r_sw_pend;
  logic [SW_CNT_W-1:0]   r_sw_cnt;
  logic                  w_defer;

  assign w_defer = w_tick && w_next_step[0] && (swing_in != 4'd0);

  // Deferred odd-step hits count down; a tick flushes anything still pending.
  always_ff @(posedge clk) begin
    if (reset || !play) begin
      r_trig    <= '0;
      r_sw_pend <= '0;
      r_sw_cnt  <= '0;
    end else if (w_start) begin
      r_trig    <= w_col & ~mute;
      r_sw_pend <= '0;
      r_sw_cnt  <= '0;
    end else if (w_tick) begin
      r_trig    <= ((w_defer ? '0 : w_col) | r_sw_pend) & ~mute;
      r_sw_pend <= w_defer ? w_col : '0;
      r_sw_cnt  <= w_defer ? (SW_CNT_W'(swing_in) << SWING_SHIFT) : '0;
    end else if (r_sw_cnt == SW_CNT_W'(1)) begin
      r_trig    <= r_sw_pend & ~mute;
      r_sw_pend <= '0;
      r_sw_cnt  <= '0;
    end else begin
      r_trig <= '0;
      if (r_sw_cnt != '0) r_sw_cnt <= r_sw_cnt - 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset || !play) begin
      r_trig <= '0;
    end else if (w_start || w_tick) begin
      r_trig <= w_col & ~mute;
    end else begin
      r_trig <= '0;
    end
  end
`endif

  assign trig_out    = r_trig;
  assign step_idx    = r_step;
  assign step_tick   = r_step_tick;
  assign pattern_out = r_pattern;

endmodule
